// File: rtl/data_c_to_axis_pack_pkg.sv
// Shared helpers and beat layout for the word-to-AXI-Stream packer.
package data_c_axis_pkg;

   // Bit width needed to encode n distinct values; never returns less than 1.
   function automatic int clog2w(input int n);
      int w;
      for (w = 1; (1 << w) < n; w++) begin
      end
      return w;
   endfunction

   // Beat layout at the default 8x4 configuration. Parameterised instances
   // build the same {last, data} layout locally at their own width.
   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } beat_t;

endpackage

// File: rtl/data_c_to_axis_pack_if.sv
// Word-stream and AXI-Stream bundles used at the packer boundary.
interface data_inf_c #(
   parameter int DSIZE = 8
);
   logic             valid;
   logic             ready;
   logic [DSIZE-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

interface axi_stream_inf #(
   parameter int DSIZE = 32
);
   localparam int KSIZE = (DSIZE + 7) / 8;

   logic             axis_tvalid;
   logic             axis_tready;
   logic [DSIZE-1:0] axis_tdata;
   logic             axis_tlast;
   logic [KSIZE-1:0] axis_tkeep;
   logic             axis_tuser;

   modport master (output axis_tvalid, output axis_tdata, output axis_tlast,
                   output axis_tkeep, output axis_tuser, input axis_tready);
   modport slave  (input axis_tvalid, input axis_tdata, input axis_tlast,
                   input axis_tkeep, input axis_tuser, output axis_tready);
endinterface

// File: rtl/data_c_to_axis_pack_fifo.sv
// Small synchronous FIFO holding packed {last, data} beats.
// A push on a full FIFO is accepted only when a pop frees the head slot
// in the same cycle.
module pack_fifo
   import data_c_axis_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [WIDTH-1:0]            wdata,
   input  logic                        pop,
   output logic [WIDTH-1:0]            rdata,
   output logic                        full,
   output logic                        empty,
   output logic [clog2w(DEPTH+1)-1:0]  count
);
   localparam int AW = clog2w(DEPTH);
   localparam int CW = clog2w(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign rdata = mem_q[rd_q];

   // Next pointers, occupancy and storage contents.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      if (do_push) begin
         mem_d[wr_q] = wdata;
      end
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   // State registers; reset empties the FIFO and zeroes the head word.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/data_c_to_axis_pack.sv
// Packs RATIO input words into one AXI-Stream beat, first word at the LSB,
// marks tlast every PKT_BEATS beats or on flush, and buffers beats in a FIFO.
module data_c_to_axis_pack
   import data_c_axis_pkg::*;
#(
   parameter int IDSIZE    = 8,
   parameter int RATIO     = 4,
   parameter int PKT_BEATS = 16,
   parameter int DEPTH     = 4
) (
   input  logic                 clock,
   input  logic                 rst_n,
   data_inf_c.slave             in_inf,
   axi_stream_inf.master        out_inf,
   input  logic                 flush,
   output logic [15:0]          pkt_cnt
);
   localparam int ODSIZE = IDSIZE * RATIO;
   localparam int IW     = clog2w(RATIO);
   localparam int BW     = clog2w(PKT_BEATS);
   localparam int CW     = clog2w(DEPTH + 1);

   localparam logic [IW-1:0] IDX_LAST  = IW'(RATIO - 1);
   localparam logic [BW-1:0] BCNT_LAST = BW'(PKT_BEATS - 1);

   typedef struct packed {
      logic              last;
      logic [ODSIZE-1:0] data;
   } pbeat_t;

   logic [IW-1:0]     idx_q, idx_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [ODSIZE-1:0] pack_q, pack_d;
   logic              fpend_q, fpend_d;
   logic [15:0]       pkt_q, pkt_d;
   logic              rdy_en_q, rdy_en_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [ODSIZE:0]   fifo_rdata;
   pbeat_t            rbeat;
   pbeat_t            wbeat;
   logic              push;
   logic              pop;
   logic              space;
   logic              in_ready;
   logic              acc;
   logic              fl;
   logic              complete;
   logic [IW-1:0]     idx_w;
   logic [ODSIZE-1:0] pack_w;

   assign rbeat = fifo_rdata;

   assign in_inf.ready       = in_ready;
   assign out_inf.axis_tvalid = (fifo_count != '0);
   assign out_inf.axis_tdata  = rbeat.data;
   assign out_inf.axis_tlast  = rbeat.last;
   assign out_inf.axis_tkeep  = '1;
   assign out_inf.axis_tuser  = 1'b0;
   assign pkt_cnt             = pkt_q;

   // Word acceptance, beat assembly, tlast decision and flush servicing.
   always_comb begin
      pop   = !fifo_empty && out_inf.axis_tready;
      space = !fifo_full || pop;
      // Completing word needs a free slot by registered count; a flush that
      // cannot be pushed yet freezes the input so the partial beat holds.
      in_ready = rdy_en_q
               && !(fifo_full && (idx_q == IDX_LAST))
               && !(fpend_q && fifo_full);
      acc      = in_inf.valid && in_ready;
      fl       = flush || fpend_q;
      complete = acc && (idx_q == IDX_LAST);

      pack_w = pack_q;
      if (acc) begin
         pack_w[int'(idx_q)*IDSIZE +: IDSIZE] = in_inf.data;
      end
      idx_w = acc ? (idx_q + IW'(1)) : idx_q;

      idx_d   = idx_w;
      pack_d  = pack_w;
      bcnt_d  = bcnt_q;
      fpend_d = fpend_q;
      push    = 1'b0;
      wbeat   = '0;

      if (complete) begin
         // A flush arriving with the completing word just closes this beat.
         push       = 1'b1;
         wbeat.data = pack_w;
         wbeat.last = (bcnt_q == BCNT_LAST) || fl;
         idx_d      = '0;
         pack_d     = '0;
         bcnt_d     = wbeat.last ? '0 : (bcnt_q + BW'(1));
         fpend_d    = 1'b0;
      end else if (fl) begin
         if (idx_w == '0) begin
            fpend_d = 1'b0;
         end else if (space) begin
            // Unfilled words are zero because pack is cleared after every push.
            push       = 1'b1;
            wbeat.data = pack_w;
            wbeat.last = 1'b1;
            idx_d      = '0;
            pack_d     = '0;
            bcnt_d     = '0;
            fpend_d    = 1'b0;
         end else begin
            fpend_d = 1'b1;
         end
      end

      pkt_d    = pkt_q + 16'(pop && rbeat.last);
      rdy_en_d = 1'b1;
   end

   // Packing state, packet counter and post-reset ready enable.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         bcnt_q   <= '0;
         pack_q   <= '0;
         fpend_q  <= 1'b0;
         pkt_q    <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         pack_q   <= pack_d;
         fpend_q  <= fpend_d;
         pkt_q    <= pkt_d;
         rdy_en_q <= rdy_en_d;
      end
   end

   pack_fifo #(
      .WIDTH (ODSIZE + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wbeat),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_data_c_to_axis_pack.sv
// Directed bench for the 8x4 packer with two-beat packets and a 4-deep FIFO.
module tb_data_c_to_axis_pack;
   localparam int IDSIZE    = 8;
   localparam int RATIO     = 4;
   localparam int PKT_BEATS = 2;
   localparam int DEPTH     = 4;
   localparam int ODSIZE    = IDSIZE * RATIO;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] pkt_cnt;

   data_inf_c     #(.DSIZE(IDSIZE)) in_if ();
   axi_stream_inf #(.DSIZE(ODSIZE)) out_if ();

   data_c_to_axis_pack #(
      .IDSIZE    (IDSIZE),
      .RATIO     (RATIO),
      .PKT_BEATS (PKT_BEATS),
      .DEPTH     (DEPTH)
   ) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .in_inf  (in_if),
      .out_inf (out_if),
      .flush   (flush),
      .pkt_cnt (pkt_cnt)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_bad = 0;

   logic [ODSIZE:0] got_q [$];
   logic [ODSIZE:0] exp_q [$];
   logic            stall_prev = 1'b0;
   logic [ODSIZE:0] hold_prev  = '0;
   logic [7:0]      rw [1000];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Capture accepted beats and check that a stalled beat holds steady.
   always @(negedge clock) begin
      if (rst_n) begin
         if (stall_prev) begin
            check("hold", {out_if.axis_tlast, out_if.axis_tdata}, hold_prev);
         end
         if (out_if.axis_tvalid && out_if.axis_tready) begin
            got_q.push_back({out_if.axis_tlast, out_if.axis_tdata});
         end
         stall_prev <= out_if.axis_tvalid && !out_if.axis_tready;
         hold_prev  <= {out_if.axis_tlast, out_if.axis_tdata};
      end else begin
         stall_prev <= 1'b0;
      end
   end

   initial begin
      #700000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_word(input logic [7:0] d, input logic fl);
      logic a;
      int   t;
      in_if.valid = 1'b1;
      in_if.data  = d;
      flush       = fl;
      t           = 0;
      forever begin
         @(negedge clock);
         a = in_if.ready;
         @(posedge clock);
         #1;
         flush = 1'b0;
         if (a) break;
         t++;
         if (t > 100) begin
            check("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      in_if.valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      got_q.delete();
      repeat (2) @(posedge clock);
      #3;
      rst_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic compare_beats(input string tag);
      check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) begin
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int       sent;
      int       cyc;
      logic     a;
      logic     lb;

      in_if.valid        = 1'b0;
      in_if.data         = '0;
      out_if.axis_tready = 1'b1;

      // reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ready", 64'(in_if.ready), 64'd0);
      check("rst_tvalid", 64'(out_if.axis_tvalid), 64'd0);
      check("rst_tdata", 64'(out_if.axis_tdata), 64'd0);
      check("rst_tlast", 64'(out_if.axis_tlast), 64'd0);
      check("rst_pkt", 64'(pkt_cnt), 64'd0);
      @(posedge clock);
      #3;
      rst_n = 1'b1;
      @(negedge clock);
      check("rel_ready_0", 64'(in_if.ready), 64'd0);
      @(posedge clock);
      #1;
      check("rel_ready_1", 64'(in_if.ready), 64'd1);
      check("tkeep", 64'(out_if.axis_tkeep), 64'hF);
      check("tuser", 64'(out_if.axis_tuser), 64'd0);

      // basic two-beat packet
      for (int i = 1; i <= 8; i++) send_word(8'(i), 1'b0);
      idle(4);
      exp_q.push_back({1'b0, 32'h04030201});
      exp_q.push_back({1'b1, 32'h08070605});
      compare_beats("basic");
      check("basic_pkt", 64'(pkt_cnt), 64'd1);

      // flush of a partial beat, then a fresh two-beat packet
      send_word(8'hAA, 1'b0);
      send_word(8'hBB, 1'b0);
      pulse_flush();
      idle(3);
      for (int i = 0; i < 8; i++) send_word(8'h11 + 8'(i), 1'b0);
      idle(4);
      exp_q.push_back({1'b1, 32'h0000BBAA});
      exp_q.push_back({1'b0, 32'h14131211});
      exp_q.push_back({1'b1, 32'h18171615});
      compare_beats("flush_part");
      check("flush_part_pkt", 64'(pkt_cnt), 64'd3);

      // flush with the completing word, then flush at a word boundary
      send_word(8'h21, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h23, 1'b0);
      send_word(8'h24, 1'b1);
      idle(2);
      pulse_flush();
      idle(3);
      check("flush_idx0_n", 64'(got_q.size()), 64'd1);
      for (int i = 0; i < 8; i++) send_word(8'h31 + 8'(i), 1'b0);
      idle(4);
      exp_q.push_back({1'b1, 32'h24232221});
      exp_q.push_back({1'b0, 32'h34333231});
      exp_q.push_back({1'b1, 32'h38373635});
      compare_beats("flush_full");
      check("flush_full_pkt", 64'(pkt_cnt), 64'd5);

      // backpressure: four beats buffered, twentieth word stalls
      do_reset();
      out_if.axis_tready = 1'b0;
      for (int i = 0; i < 19; i++) send_word(8'h40 + 8'(i), 1'b0);
      in_if.valid = 1'b1;
      in_if.data  = 8'h53;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("bp_ready", 64'(in_if.ready), 64'd0);
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      check("bp_tvalid", 64'(out_if.axis_tvalid), 64'd1);
      check("bp_head", 64'(out_if.axis_tdata), 64'h43424140);
      check("bp_none_out", 64'(got_q.size()), 64'd0);
      @(posedge clock);
      #1;
      out_if.axis_tready = 1'b1;
      a = 1'b0;
      for (int t = 0; t < 20 && !a; t++) begin
         @(negedge clock);
         a = in_if.ready;
         @(posedge clock);
         #1;
      end
      check("bp_accept", 64'(a), 64'd1);
      in_if.valid = 1'b0;
      idle(10);
      for (int b = 0; b < 5; b++) begin
         lb = (b % 2 == 1);
         exp_q.push_back({lb, 8'h40 + 8'(4*b+3), 8'h40 + 8'(4*b+2),
                              8'h40 + 8'(4*b+1), 8'h40 + 8'(4*b)});
      end
      compare_beats("bp");
      check("bp_pkt", 64'(pkt_cnt), 64'd2);

      // random valid/ready against a reference packer
      do_reset();
      for (int i = 0; i < 1000; i++) rw[i] = 8'($urandom);
      sent = 0;
      cyc  = 0;
      while (sent < 1000 && cyc < 40000) begin
         in_if.valid        = 1'($urandom % 2);
         in_if.data         = rw[sent];
         out_if.axis_tready = 1'($urandom % 2);
         @(negedge clock);
         a = in_if.valid && in_if.ready;
         @(posedge clock);
         #1;
         if (a) sent++;
         cyc++;
      end
      in_if.valid        = 1'b0;
      out_if.axis_tready = 1'b1;
      check("rand_sent", 64'(sent), 64'd1000);
      idle(30);
      for (int b = 0; b < 250; b++) begin
         lb = (b % 2 == 1);
         exp_q.push_back({lb, rw[4*b+3], rw[4*b+2], rw[4*b+1], rw[4*b]});
      end
      compare_beats("rand");
      check("rand_pkt", 64'(pkt_cnt), 64'd125);

      // reset mid-beat with two beats buffered
      out_if.axis_tready = 1'b0;
      for (int i = 0; i < 10; i++) send_word(8'h70 + 8'(i), 1'b0);
      idle(1);
      check("mid_tvalid_pre", 64'(out_if.axis_tvalid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_tvalid", 64'(out_if.axis_tvalid), 64'd0);
      check("mid_pkt", 64'(pkt_cnt), 64'd0);
      check("mid_ready", 64'(in_if.ready), 64'd0);
      check("mid_tdata", 64'(out_if.axis_tdata), 64'd0);
      got_q.delete();
      repeat (2) @(posedge clock);
      #3;
      rst_n = 1'b1;
      out_if.axis_tready = 1'b1;
      for (int i = 0; i < 4; i++) send_word(8'h61 + 8'(i), 1'b0);
      idle(4);
      exp_q.push_back({1'b0, 32'h64636261});
      compare_beats("post_rst");
      check("post_rst_pkt", 64'(pkt_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
